// File: rtl/mux8_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_arbiter
//
// Round-robin arbiter that shares one 8:1 bit-select mux between eight
// requesters. The binary select `s` goes to the mux. The one-hot `grant`
// goes back to the requesters.
//
// A grant is held while its requester keeps `req` high. When other
// requesters are waiting, the holder is pre-empted after MAX_HOLD cycles.
// On release the next winner is granted on the same edge, so there is no
// idle cycle between grants. The search restarts just above the previous
// holder.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles under contention (1..15)
//   HOLD_W    hold counter width, 2**HOLD_W > MAX_HOLD
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst     in   1  asynchronous, active-high reset
//   req     in   8  level-sensitive request lines, bit n = requester n
//   grant   out  8  registered one-hot grant, zero when idle
//   s       out  3  registered binary index of the granted requester
//   active  out  1  registered, high while a grant is held (== |grant)
// ---------------------------------------------------------------------------
module mux8_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] s,
  output logic       active
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } search_t;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_t            state;
  logic [2:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [2:0] search_start;
  logic [7:0] other_req;
  logic       hold_expired;
  logic       release_now;
  search_t    win;

  // Finds the first set bit of r, scanning upward from start and wrapping
  // modulo 8.
  // The vector is rotated so that `start` lands at bit 0. The lowest set
  // bit of the rotated vector is then the winner's offset from `start`.
  function automatic search_t rr_search(input logic [7:0] r,
                                        input logic [2:0] start);
    logic [15:0] doubled;
    logic [7:0]  rotated;
    search_t     res;
    doubled   = {r, r} >> start;
    rotated   = doubled[7:0];
    res.found = 1'b0;
    res.idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rotated[k]) begin
        res.found = 1'b1;
        res.idx   = start + 3'(k);
      end
    end
    return res;
  endfunction

  // NOTE: every always_comb output gets a default before any branch, so a
  // missed path can never infer a latch.
  always_comb begin
    search_start = ptr;
    other_req    = req;
    other_req[s] = 1'b0;
    hold_expired = (hold_cnt == HOLD_MAX);
    release_now  = 1'b0;
    if (state == BUSY) begin
      // The holder is released when it drops its request, or when its hold
      // time is used up and somebody else is waiting.
      release_now  = !req[s] || (hold_expired && (other_req != 8'd0));
      // The search starts just above the releasing holder. The holder
      // therefore comes last, and it can win only when nobody else is
      // asking.
      search_start = s + 3'd1;
    end
    win = rr_search(req, search_start);
  end

  // NOTE: all state and output registers use non-blocking assignments, so
  // every register samples its inputs from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      hold_cnt <= '0;
      grant    <= 8'd0;
      s        <= 3'd0;
      active   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win.found) begin
            state    <= BUSY;
            grant    <= 8'd1 << win.idx;
            s        <= win.idx;
            active   <= 1'b1;
            hold_cnt <= HOLD_ONE;
          end
        end

        BUSY: begin
          if (release_now) begin
            ptr <= s + 3'd1;
            if (win.found) begin
              // Back-to-back hand-over: the old grant drops and the new
              // grant rises on the same edge.
              grant    <= 8'd1 << win.idx;
              s        <= win.idx;
              hold_cnt <= HOLD_ONE;
            end else begin
              // Nobody is asking. `s` keeps its last value, so the mux
              // select does not move when the grant drops.
              state    <= IDLE;
              grant    <= 8'd0;
              active   <= 1'b0;
              hold_cnt <= '0;
            end
          end else if (!hold_expired) begin
            // The counter saturates. A sole requester can keep the grant
            // indefinitely, and it is pre-empted on the first edge after a
            // competitor appears.
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_arbiter
//
// Self-checking bench for mux8_arbiter with MAX_HOLD = 4. Directed scenarios
// check against explicit expected values. A randomized run checks against a
// behavioural model that tracks holder, hold time and round-robin start as
// plain integers.
// ---------------------------------------------------------------------------
module tb_mux8_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'd0;
  logic [7:0] grant;
  logic [2:0] s;
  logic       active;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit m_busy;
  int m_s;
  int m_ptr;
  int m_hold;

  mux8_arbiter #(
    .MAX_HOLD(MAX_HOLD),
    .HOLD_W  (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .s     (s),
    .active(active)
  );

  always #5 clk = ~clk;

  function automatic int first_from(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [11:0] model_out();
    logic [7:0] g;
    g = m_busy ? 8'(1 << m_s) : 8'd0;
    return {g, 3'(m_s), m_busy};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_s    = 0;
    m_ptr  = 0;
    m_hold = 0;
  endtask

  // Advances the model using the req that the DUT will sample. The task
  // then waits for the edge and returns 1 time unit after it.
  task automatic tick();
    int         w;
    logic [7:0] others;
    if (!m_busy) begin
      w = first_from(req, m_ptr);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_s    = w;
        m_hold = 1;
      end
    end else begin
      others       = req;
      others[m_s]  = 1'b0;
      if (!req[m_s] || (m_hold == MAX_HOLD && others != 8'd0)) begin
        m_ptr = (m_s + 1) % 8;
        w     = first_from(req, m_ptr);
        if (w >= 0) begin
          m_s    = w;
          m_hold = 1;
        end else begin
          m_busy = 1'b0;
          m_hold = 0;
        end
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed mid-cycle, away from any edge.
  task automatic do_reset();
    req = 8'd0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({grant, s, active} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_initial: got grant=%h s=%0d active=%b, want 00/0/0",
               grant, s, active);
    end
    rst = 1'b0;
    req = 8'h08;
    tick();
    n_tests++;
    if (grant !== 8'h08 || s !== 3'd3 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: got grant=%h s=%0d active=%b, want 08/3/1",
               grant, s, active);
    end
    // Assert reset asynchronously in the middle of a held grant.
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({grant, s, active} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: got grant=%h s=%0d active=%b, want 00/0/0",
               grant, s, active);
    end
    rst = 1'b0;
    model_reset();
    tick();
    n_tests++;
    if (grant !== 8'h08 || s !== 3'd3 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_regrant: got grant=%h s=%0d active=%b, want 08/3/1",
               grant, s, active);
    end
  endtask

  task automatic test_single_request();
    do_reset();
    req = 8'h04;
    tick();
    n_tests++;
    if (grant !== 8'h04 || s !== 3'd2 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%h s=%0d active=%b, want 04/2/1",
               grant, s, active);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      n_tests++;
      if (grant !== 8'h04 || s !== 3'd2) begin
        n_fail++;
        $display("FAIL single_hold c=%0d: got grant=%h s=%0d, want 04/2",
                 c, grant, s);
      end
    end
    req = 8'd0;
    tick();
    n_tests++;
    if (grant !== 8'h00 || s !== 3'd2 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drop: got grant=%h s=%0d active=%b, want 00/2/0",
               grant, s, active);
    end
  endtask

  task automatic test_preempt_wrap();
    logic [7:0] eg;
    logic [2:0] es;
    do_reset();
    req = 8'h81;
    for (int c = 0; c < 16; c++) begin
      tick();
      eg = ((c / MAX_HOLD) % 2 == 0) ? 8'h01 : 8'h80;
      es = ((c / MAX_HOLD) % 2 == 0) ? 3'd0 : 3'd7;
      n_tests++;
      if (grant !== eg || s !== es || active !== 1'b1) begin
        n_fail++;
        $display("FAIL preempt_wrap c=%0d: got grant=%h s=%0d active=%b, want %h/%0d/1",
                 c, grant, s, active, eg, es);
      end
    end
  endtask

  task automatic test_fairness();
    int timer [8];
    do_reset();
    req = 8'hFF;
    foreach (timer[i]) timer[i] = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      n_tests++;
      if (grant !== 8'(1 << (c % 8)) || s !== 3'(c % 8)) begin
        n_fail++;
        $display("FAIL fairness step=%0d: got grant=%h s=%0d, want index %0d",
                 c, grant, s, c % 8);
      end
      // Each requester drops its bit right after being granted and raises it
      // again two cycles later.
      for (int i = 0; i < 8; i++) begin
        if (grant[i]) begin
          req[i]   = 1'b0;
          timer[i] = 2;
        end else if (timer[i] > 0) begin
          timer[i]--;
          if (timer[i] == 0) req[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 8'h04;
    tick();
    req = 8'h24;
    tick();
    req = 8'h20;
    tick();
    n_tests++;
    if (grant !== 8'h20 || s !== 3'd5 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_move: got grant=%h s=%0d active=%b, want 20/5/1",
               grant, s, active);
    end
    // The hold count must restart at 1, so with contention requester 5
    // keeps the grant for three more edges and loses it on the fourth.
    req = 8'h24;
    for (int k = 0; k < MAX_HOLD; k++) begin
      tick();
      n_tests++;
      if (grant !== ((k < MAX_HOLD - 1) ? 8'h20 : 8'h04)) begin
        n_fail++;
        $display("FAIL b2b_hold_restart k=%0d: got grant=%h, want %h",
                 k, grant, (k < MAX_HOLD - 1) ? 8'h20 : 8'h04);
      end
    end
  endtask

  task automatic test_late_arrival();
    do_reset();
    req = 8'h02;
    repeat (10) tick();
    n_tests++;
    if (grant !== 8'h02 || s !== 3'd1) begin
      n_fail++;
      $display("FAIL late_sole: got grant=%h s=%0d, want 02/1", grant, s);
    end
    req = 8'h06;
    tick();
    n_tests++;
    if (grant !== 8'h04 || s !== 3'd2 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL late_preempt: got grant=%h s=%0d active=%b, want 04/2/1",
               grant, s, active);
    end
  endtask

  task automatic test_random();
    logic [11:0] exp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0:       req = 8'd0;
          1:       req = 8'($urandom);
          default: req = 8'($urandom & $urandom);
        endcase
      end
      tick();
      exp = model_out();
      n_tests++;
      if ({grant, s, active} !== exp) begin
        n_fail++;
        $display("FAIL random c=%0d req=%h: got grant=%h s=%0d active=%b, want %h/%0d/%b",
                 c, req, grant, s, active, exp[11:4], exp[3:1], exp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_preempt_wrap();
    test_fairness();
    test_back_to_back();
    test_late_arrival();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
